// File: rtl/dma_mem_responder.sv
// Single-port-style word memory answering one read at a time with a fixed,
// parameterised latency; writes are fire-and-forget and accepted whenever idle.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | ready for a read and/or a write this cycle
// RD_WAIT | read captured, counting down the remaining latency
// RD_RESP | resp_valid high for this single cycle, back to IDLE next
module dma_mem_responder #(
   parameter int DEPTH_LOG2   = 8,
   parameter int READ_LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic [31:0] req_addr,
   output logic        req_ready,
   output logic        resp_valid,
   output logic [31:0] resp_data,
   input  logic        write_valid,
   input  logic [31:0] write_addr,
   input  logic [31:0] write_data,
   output logic        write_ready,
   output logic [15:0] rd_count,
   output logic [15:0] wr_count
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   // RD_WAIT lasts READ_LATENCY-1 cycles; the counter terminates at zero.
   localparam logic [3:0] LAT_LOAD = (READ_LATENCY > 1) ? 4'(READ_LATENCY - 2) : 4'd0;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_WAIT = 2'd1,
      RD_RESP = 2'd2
   } state_t;

   state_t                state;
   logic [31:0]           mem [DEPTH];
   logic [DEPTH_LOG2-1:0] rd_idx;
   logic [DEPTH_LOG2-1:0] req_idx;
   logic [DEPTH_LOG2-1:0] wr_idx;
   logic [3:0]            lat_cnt;
   logic                  rd_fire;
   logic                  wr_fire;
   logic [31:0]           fwd_data;
   logic                  unused_addr_bits;

   // Readiness depends on state and reset only, never on the valids.
   assign req_ready   = rst && (state == IDLE);
   assign write_ready = rst && (state == IDLE);

   assign rd_fire = req_valid && req_ready;
   assign wr_fire = write_valid && write_ready;

   // Byte offset and upper bits are dropped, so addresses alias.
   assign req_idx = req_addr[DEPTH_LOG2+1:2];
   assign wr_idx  = write_addr[DEPTH_LOG2+1:2];
   assign unused_addr_bits = ^{req_addr[31:DEPTH_LOG2+2], req_addr[1:0],
                               write_addr[31:DEPTH_LOG2+2], write_addr[1:0]};

   // A same-cycle write to the read index must be visible to a 1-cycle read.
   assign fwd_data = (wr_fire && (wr_idx == req_idx)) ? write_data : mem[req_idx];

   // Backing array: never reset, written only on an accepted write.
   always_ff @(posedge clk) begin
      if (wr_fire) begin
         mem[wr_idx] <= write_data;
      end
   end

   // Read sequencing FSM with registered response outputs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         resp_valid <= 1'b0;
         resp_data  <= '0;
         rd_idx     <= '0;
         lat_cnt    <= '0;
      end else begin
         resp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (rd_fire) begin
                  rd_idx <= req_idx;
                  if (READ_LATENCY == 1) begin
                     state      <= RD_RESP;
                     resp_valid <= 1'b1;
                     resp_data  <= fwd_data;
                  end else begin
                     state   <= RD_WAIT;
                     lat_cnt <= LAT_LOAD;
                  end
               end
            end
            RD_WAIT: begin
               if (lat_cnt == 4'd0) begin
                  state      <= RD_RESP;
                  resp_valid <= 1'b1;
                  resp_data  <= mem[rd_idx];
               end else begin
                  lat_cnt <= lat_cnt - 4'd1;
               end
            end
            RD_RESP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Accepted-request counters, wrapping modulo 2^16.
   always_ff @(posedge clk) begin
      if (!rst) begin
         rd_count <= '0;
         wr_count <= '0;
      end else begin
         if (rd_fire) begin
            rd_count <= rd_count + 16'd1;
         end
         if (wr_fire) begin
            wr_count <= wr_count + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_dma_mem_responder.sv
// Randomised bench for dma_mem_responder: a driver steps one cycle at a time
// and posts accepted reads to a scoreboard; a negedge monitor checks them.
module tb_dma_mem_responder;

   localparam int L     = 2;
   localparam int DL    = 8;
   localparam int DEPTH = 1 << DL;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        req_valid, req_ready, resp_valid, write_valid, write_ready;
   logic [31:0] req_addr, resp_data, write_addr, write_data;
   logic [15:0] rd_count, wr_count;

   logic        req_valid_1, req_ready_1, resp_valid_1, write_valid_1, write_ready_1;
   logic [31:0] req_addr_1, resp_data_1, write_addr_1, write_data_1;
   logic [15:0] rd_count_1, wr_count_1;

   dma_mem_responder #(.DEPTH_LOG2(DL), .READ_LATENCY(L)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
      .resp_valid(resp_valid), .resp_data(resp_data),
      .write_valid(write_valid), .write_addr(write_addr), .write_data(write_data),
      .write_ready(write_ready), .rd_count(rd_count), .wr_count(wr_count)
   );

   dma_mem_responder #(.DEPTH_LOG2(DL), .READ_LATENCY(1)) dut1 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid_1), .req_addr(req_addr_1), .req_ready(req_ready_1),
      .resp_valid(resp_valid_1), .resp_data(resp_data_1),
      .write_valid(write_valid_1), .write_addr(write_addr_1), .write_data(write_data_1),
      .write_ready(write_ready_1), .rd_count(rd_count_1), .wr_count(wr_count_1)
   );

   typedef struct {
      logic [31:0] data;
      int          cyc;
   } exp_t;

   // Driver-owned reference model state
   logic [31:0] model_mem [DEPTH];
   logic [31:0] mem1 [4];
   int          cyc = 0;
   int          next_ready = 0;
   logic [15:0] m_rd = '0, m_wr = '0;
   bit          mon_en = 1'b0;
   bit          ev_push = 1'b0, ev_rst = 1'b0;
   logic [31:0] ev_data = '0;
   int          ev_cyc = 0;
   bit          e1_en = 1'b0, e1_valid = 1'b0;
   logic [31:0] e1_data = '0;
   logic [15:0] e1_rd = '0, e1_wr = '0;

   // Monitor-owned scoreboard state
   exp_t        q[$];
   logic [31:0] m_last = '0;
   int          tests = 0, fails = 0;

   function automatic int widx(input logic [31:0] a);
      return int'((a >> 2) % 32'(DEPTH));
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         if (fails <= 40) $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
      end
   endtask

   // One clock of stimulus; the model decides acceptance from its own view of readiness.
   task automatic step(input bit r, input bit rv, input logic [31:0] ra,
                       input bit wv, input logic [31:0] wa, input logic [31:0] wd);
      bit rdy;
      rst = r; req_valid = rv; req_addr = ra;
      write_valid = wv; write_addr = wa; write_data = wd;
      rdy = r && (cyc >= next_ready);
      @(posedge clk);
      cyc++;
      ev_push = 1'b0;
      ev_rst  = 1'b0;
      if (!r) begin
         ev_rst = 1'b1; m_rd = '0; m_wr = '0; next_ready = 0;
      end else if (rdy) begin
         if (wv) begin
            model_mem[widx(wa)] = wd;
            m_wr++;
         end
         if (rv) begin
            ev_push = 1'b1;
            ev_data = model_mem[widx(ra)];
            ev_cyc  = cyc + L - 1;
            m_rd++;
            next_ready = cyc + L;
         end
      end
      #1;
   endtask

   task automatic idle_step();
      step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
   endtask

   // Scoreboard monitor, sampling on the falling edge.
   always @(negedge clk) begin
      if (mon_en) begin
         if (ev_rst) begin
            q.delete();
            m_last = '0;
         end
         if (ev_push) q.push_back('{ev_data, ev_cyc});
         check("req_ready", 32'(req_ready), 32'(rst && (cyc >= next_ready)));
         check("write_ready", 32'(write_ready), 32'(rst && (cyc >= next_ready)));
         check("rd_count", 32'(rd_count), 32'(m_rd));
         check("wr_count", 32'(wr_count), 32'(m_wr));
         if (resp_valid) begin
            if (q.size() == 0) begin
               check("unexpected_resp_valid", 32'(resp_valid), 32'd0);
            end else begin
               exp_t e;
               e = q.pop_front();
               check("resp_cycle", 32'(cyc), 32'(e.cyc));
               check("resp_data", resp_data, e.data);
               m_last = e.data;
            end
         end else begin
            check("resp_data_hold", resp_data, m_last);
            if (q.size() > 0 && cyc >= q[0].cyc) begin
               check("missing_resp_valid", 32'(resp_valid), 32'd1);
               void'(q.pop_front());
            end
         end
         if (e1_en) begin
            check("l1_resp_valid", 32'(resp_valid_1), 32'(e1_valid));
            check("l1_req_ready", 32'(req_ready_1), 32'(!e1_valid));
            check("l1_resp_data", resp_data_1, e1_data);
            check("l1_rd_count", 32'(rd_count_1), 32'(e1_rd));
            check("l1_wr_count", 32'(wr_count_1), 32'(e1_wr));
         end
      end
   end

   initial begin
      req_valid_1 = 1'b0; req_addr_1 = '0;
      write_valid_1 = 1'b0; write_addr_1 = '0; write_data_1 = '0;

      repeat (3) step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
      mon_en = 1'b1;

      // Fill every word so all random reads have defined data.
      for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 32'h0, 1'b1, 32'(i * 4), $urandom);

      // Write then read at latency 2.
      step(1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
      step(1'b1, 1'b1, 32'h0000_0010, 1'b0, 32'h0, 32'h0);
      repeat (3) idle_step();

      // Simultaneous write and read of the same word from a clean reset.
      step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
      step(1'b1, 1'b1, 32'h20, 1'b1, 32'h20, 32'h1234_5678);
      repeat (3) idle_step();

      // Aliasing and byte-offset ignore.
      step(1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_0400, 32'hA5A5_A5A5);
      step(1'b1, 1'b1, 32'h0000_0003, 1'b0, 32'h0, 32'h0);
      repeat (3) idle_step();

      // Random traffic with occasional resets.
      for (int i = 0; i < 1500; i++) begin
         step(($urandom_range(63) != 0), $urandom_range(1) == 1, $urandom,
              $urandom_range(1) == 1, $urandom, $urandom);
      end
      repeat (4) idle_step();

      // Reset while a read is pending: no response may ever appear.
      step(1'b1, 1'b1, 32'h0000_0040, 1'b0, 32'h0, 32'h0);
      step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
      repeat (4) idle_step();

      // wr_count wrap: 65537 back-to-back writes from reset.
      step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
      for (int i = 0; i < 65537; i++) step(1'b1, 1'b0, 32'h0, 1'b1, $urandom, $urandom);
      idle_step();

      // Latency-1 instance: forwarding and one response every two cycles.
      step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
      e1_en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         mem1[i] = $urandom;
         write_valid_1 = 1'b1; write_addr_1 = 32'(i * 4); write_data_1 = mem1[i];
         idle_step();
         e1_wr++;
      end
      mem1[2] = 32'h0BAD_F00D;
      write_valid_1 = 1'b1; write_addr_1 = 32'h8; write_data_1 = mem1[2];
      req_valid_1 = 1'b1; req_addr_1 = 32'h8;
      idle_step();
      e1_wr++; e1_rd++; e1_valid = 1'b1; e1_data = mem1[2];
      write_valid_1 = 1'b0;
      for (int k = 0; k < 16; k++) begin
         req_valid_1 = 1'b1;
         req_addr_1 = 32'((((k >> 1) & 3) << 2) | (k & 3));
         idle_step();
         e1_valid = (k % 2) == 1;
         if (e1_valid) begin
            e1_rd++;
            e1_data = mem1[(k >> 1) & 3];
         end
      end
      req_valid_1 = 1'b0;
      idle_step();
      e1_valid = 1'b0;
      idle_step();
      e1_en = 1'b0;
      idle_step();

      if (q.size() != 0) $display("FAIL scoreboard_drain: %0d responses outstanding, expected 0", q.size());
      $display("[TB] %0d tests run, %0d failed", tests, fails + ((q.size() != 0) ? 1 : 0));
      $finish;
   end

endmodule

// File: doc/dma_mem_responder.md
DMA_MEM_RESPONDER -- requirements
Module: dma_mem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_LOG2, default 8, meaning log2 of the number of 32-bit words in the backing array.
REQ-002 The block SHALL have parameter READ_LATENCY, default 2, legal range 1..15, meaning cycles from read acceptance to resp_valid.
REQ-003 The block SHALL have port clk, input, width 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, width 1, reset; reset is synchronous and active-low.
REQ-005 The block SHALL have port req_valid, input, width 1, read request present.
REQ-006 The block SHALL have port req_addr, input, width 32, read byte address.
REQ-007 The block SHALL have port req_ready, output, width 1, read request can be accepted this cycle.
REQ-008 The block SHALL have port resp_valid, output, width 1, read data valid; single-cycle pulse with no back-pressure.
REQ-009 The block SHALL have port resp_data, output, width 32, read data.
REQ-010 The block SHALL have port write_valid, input, width 1, write request present.
REQ-011 The block SHALL have port write_addr, input, width 32, write byte address.
REQ-012 The block SHALL have port write_data, input, width 32, write data.
REQ-013 The block SHALL have port write_ready, output, width 1, write can be accepted this cycle.
REQ-014 The block SHALL have port rd_count, output, width 16, number of accepted reads, wraps modulo 2^16.
REQ-015 The block SHALL have port wr_count, output, width 16, number of accepted writes, wraps modulo 2^16.

Function
REQ-016 A handshake SHALL occur in any cycle where valid and ready are both high at the rising edge; no other condition accepts a request.
REQ-017 The word index SHALL be addr[DEPTH_LOG2+1:2]; addr[1:0] and bits above DEPTH_LOG2+1 SHALL be ignored, so addresses alias modulo 4*2^DEPTH_LOG2.
REQ-018 The state machine SHALL have states IDLE, RD_WAIT and RD_RESP.
REQ-019 In IDLE, req_ready and write_ready SHALL both be 1; in RD_WAIT and RD_RESP, both SHALL be 0, so at most one read is outstanding.
REQ-020 req_ready and write_ready SHALL be combinational functions of state and rst only, and SHALL never depend on req_valid or write_valid.
REQ-021 On write acceptance, write_data SHALL be stored at the indexed word at that rising edge; there is no write response and the state is unchanged.
REQ-022 On read acceptance at edge T, the index SHALL be captured, and the state SHALL go to RD_RESP if READ_LATENCY=1, otherwise to RD_WAIT with a latency counter loaded.
REQ-023 RD_WAIT SHALL move to RD_RESP so that resp_valid is high in exactly the cycle following edge T+READ_LATENCY-1, i.e. READ_LATENCY cycles after acceptance.
REQ-024 In RD_RESP, resp_valid SHALL be 1 for exactly one cycle, resp_data SHALL hold the array word at the captured index, and the next state SHALL be IDLE.
REQ-025 resp_data SHALL hold its last value while resp_valid is 0.
REQ-026 If a write and a read are accepted in the same IDLE cycle, the write SHALL commit first, and a read of the same index SHALL return the new data.
REQ-027 Maximum read throughput SHALL be one read every READ_LATENCY+1 cycles; a write SHALL be accepted in any IDLE cycle.
REQ-028 rd_count and wr_count SHALL each increment by 1 per accepted request and wrap from 0xFFFF to 0x0000.

Reset
REQ-029 While rst=0 at a rising edge: state SHALL become IDLE, resp_valid=0, resp_data=0, rd_count=0, wr_count=0, and any pending read SHALL be discarded with no response ever issued.
REQ-030 While rst=0, req_ready and write_ready SHALL be 0, and no request SHALL be accepted.
REQ-031 Array contents SHALL NOT be reset; they are undefined until written.
REQ-032 The first cycle with rst=1 after reset SHALL present IDLE, with req_ready=1 and write_ready=1.

Verification
REQ-033 Write 0xDEADBEEF to 0x0000_0010, then read 0x0000_0010 at edge T with READ_LATENCY=2 -> resp_valid=1 only in the cycle after edge T+1, resp_data=0xDEADBEEF, and req_ready=0 for 2 cycles after T.
REQ-034 Simultaneous write 0x12345678 to 0x20 and read of 0x20 in IDLE -> both accepted, resp_data=0x12345678, rd_count=1, wr_count=1.
REQ-035 DEPTH_LOG2=8: write 0xA5A5A5A5 to 0x0000_0400, then read 0x0000_0003 -> resp_data=0xA5A5A5A5 (alias and byte-offset ignore).
REQ-036 Accept a read, then drive rst=0 for one cycle before the response -> no resp_valid pulse, rd_count=0, and req_ready=1 in the first cycle after reset release.
REQ-037 Issue 65537 writes -> wr_count=0x0001; back-to-back reads with READ_LATENCY=1 -> one resp_valid pulse every 2 cycles.
